// File: rtl/instr_fifo_writer.sv
// Host-side producer for the video processor instruction FIFO: edge-detects start, screens
// the opcode, buffers DEPTH instructions and drains them under wrfull. Optional counter: VP_INSTR_COUNT_EN.
module instr_fifo_writer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_dataA,
    input  logic [31:0] in_dataB,
    input  logic        start,
    input  logic        wrfull,
    input  logic        clear_flags,
    output logic [31:0] out_dataA,
    output logic [31:0] out_dataB,
    output logic        wrreq,
    output logic        busy,
    output logic        overflow,
    output logic        bad_opcode,
    output logic [15:0] instr_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [31:0] data_a;
        logic [31:0] data_b;
    } instr_t;

    instr_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            start_q;
    logic            overflow_q, overflow_d;
    logic            bad_opcode_q, bad_opcode_d;

    logic            submit_c;
    logic            op_ok_c;
    logic            full_c;
    logic            pop_c;
    logic            push_c;

    // Next-state: pointers, occupancy and sticky error flags
    always_comb begin
        submit_c     = start & ~start_q;
        op_ok_c      = (in_dataA[3:2] == 2'b00);
        full_c       = (count_q == CW'(DEPTH));
        pop_c        = (count_q != '0) & ~wrfull;
        push_c       = submit_c & op_ok_c & (~full_c | pop_c);

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        bad_opcode_d = bad_opcode_q;

        if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A new error in the same cycle as clear_flags leaves the flag set
        if (clear_flags) begin
            overflow_d   = 1'b0;
            bad_opcode_d = 1'b0;
        end
        if (submit_c & op_ok_c & full_c & ~pop_c) overflow_d   = 1'b1;
        if (submit_c & ~op_ok_c)                  bad_opcode_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            start_q      <= 1'b0;
            overflow_q   <= 1'b0;
            bad_opcode_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            start_q      <= start;
            overflow_q   <= overflow_d;
            bad_opcode_q <= bad_opcode_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= '{data_a: in_dataA, data_b: in_dataB};
        end
    end

    // Write port is driven straight from the buffer head so wrfull gates wrreq in-cycle
    assign wrreq      = pop_c;
    assign busy       = (count_q != '0);
    assign out_dataA  = mem_q[rd_ptr_q].data_a;
    assign out_dataB  = mem_q[rd_ptr_q].data_b;
    assign overflow   = overflow_q;
    assign bad_opcode = bad_opcode_q;

`ifdef VP_INSTR_COUNT_EN
    logic [15:0] instr_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      instr_count_q <= '0;
        else if (pop_c) instr_count_q <= instr_count_q + 16'd1;
    end

    assign instr_count = instr_count_q;
`else
    assign instr_count = 16'h0000;
`endif

endmodule
